// File: rtl/clock_display_scan.sv
// clock_display_scan
// Six-digit multiplexed seven-segment driver for the digital clock.
// Scans the six BCD time digits onto a common-anode display, one digit per
// slot, and blinks the colon dots on the minute-ones and hour-ones digits.
// All six digits are captured together at the start of each scan frame, so
// a counter carry never shows a torn time.
//
// Optional feature: define CLOCK_DISP_LZ_BLANK_EN to blank the hour tens
// digit when its captured value is zero. With the macro undefined, the
// hour tens digit is always lit and a zero shows as "0".
module clock_display_scan #(
  parameter int SCAN_DIV  = 50000,     // clk cycles per digit slot, >= 2
  parameter int BLINK_DIV = 25000000   // clk cycles per dot blink phase, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_2,
  input  logic [3:0] min_1,
  input  logic [3:0] min_2,
  input  logic [3:0] hour_1,
  input  logic [3:0] hour_2,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Counter widths follow their modulus; a modulus of 1 still needs one bit.
  localparam int DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [5:0] AN_ALL_OFF  = 6'b111111;
  localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;

  // Slot states, numbered in scan order from the rightmost digit.
  typedef enum logic [2:0] {
    SLOT_SEC1  = 3'd0,
    SLOT_SEC2  = 3'd1,
    SLOT_MIN1  = 3'd2,
    SLOT_MIN2  = 3'd3,
    SLOT_HOUR1 = 3'd4,
    SLOT_HOUR2 = 3'd5
  } slot_e;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // BCD digit to active-low segment pattern {g,f,e,d,c,b,a}; 10..15 -> dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  // Slot to active-low digit enable; exactly one bit low for a valid slot.
  function automatic logic [5:0] an_decode(input slot_e slot);
    logic [5:0] en;
    case (slot)
      SLOT_SEC1:  en = 6'b111110;
      SLOT_SEC2:  en = 6'b111101;
      SLOT_MIN1:  en = 6'b111011;
      SLOT_MIN2:  en = 6'b110111;
      SLOT_HOUR1: en = 6'b101111;
      SLOT_HOUR2: en = 6'b011111;
      default:    en = AN_ALL_OFF;
    endcase
    return en;
  endfunction

  // Next slot in scan order; the last slot wraps back to the first.
  function automatic slot_e slot_advance(input slot_e slot);
    slot_e nxt;
    case (slot)
      SLOT_SEC1:  nxt = SLOT_SEC2;
      SLOT_SEC2:  nxt = SLOT_MIN1;
      SLOT_MIN1:  nxt = SLOT_MIN2;
      SLOT_MIN2:  nxt = SLOT_HOUR1;
      SLOT_HOUR1: nxt = SLOT_HOUR2;
      SLOT_HOUR2: nxt = SLOT_SEC1;
      default:    nxt = SLOT_SEC1;
    endcase
    return nxt;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
  slot_e            slot_q,      slot_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q,     phase_d;

  // Frame snapshot of the six time digits.
  logic [3:0] snap_sec1_q,  snap_sec1_d;
  logic [3:0] snap_sec2_q,  snap_sec2_d;
  logic [3:0] snap_min1_q,  snap_min1_d;
  logic [3:0] snap_min2_q,  snap_min2_d;
  logic [3:0] snap_hour1_q, snap_hour1_d;
  logic [3:0] snap_hour2_q, snap_hour2_d;

  // Registered display outputs.
  logic [5:0] an_q,  an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q,  dp_d;

  logic       tick_s;
  logic       frame_end_s;
  logic       blink_wrap_s;
  logic [3:0] digit_s;
  logic       dot_slot_s;

  // Prescaler, slot counter, blink counter and snapshot next-state.
  always_comb begin
    tick_s       = (div_cnt_q == DIV_LAST);
    frame_end_s  = tick_s && (slot_q == SLOT_HOUR2);
    blink_wrap_s = (blink_cnt_q == BLK_LAST);

    if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      slot_d    = slot_advance(slot_q);
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      slot_d    = slot_q;
    end

    // Blink runs independently of the scan; a wrap coinciding with a tick
    // is simply handled in parallel.
    if (blink_wrap_s) begin
      blink_cnt_d = {BLK_W{1'b0}};
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
      phase_d     = phase_q;
    end

    // All six digits load together on the edge where slot wraps to 0,
    // so the next frame starts with a coherent time.
    if (frame_end_s) begin
      snap_sec1_d  = sec_1;
      snap_sec2_d  = sec_2;
      snap_min1_d  = min_1;
      snap_min2_d  = min_2;
      snap_hour1_d = hour_1;
      snap_hour2_d = hour_2;
    end else begin
      snap_sec1_d  = snap_sec1_q;
      snap_sec2_d  = snap_sec2_q;
      snap_min1_d  = snap_min1_q;
      snap_min2_d  = snap_min2_q;
      snap_hour1_d = snap_hour1_q;
      snap_hour2_d = snap_hour2_q;
    end
  end

  // Select the snapshot digit belonging to the current slot.
  always_comb begin
    digit_s = 4'd0;
    case (slot_q)
      SLOT_SEC1:  digit_s = snap_sec1_q;
      SLOT_SEC2:  digit_s = snap_sec2_q;
      SLOT_MIN1:  digit_s = snap_min1_q;
      SLOT_MIN2:  digit_s = snap_min2_q;
      SLOT_HOUR1: digit_s = snap_hour1_q;
      SLOT_HOUR2: digit_s = snap_hour2_q;
      default:    digit_s = 4'd0;
    endcase
  end

  // Display output next-state from the current slot, snapshot and phase.
  always_comb begin
    an_d  = an_decode(slot_q);
    seg_d = seg_encode(digit_s);

`ifdef CLOCK_DISP_LZ_BLANK_EN
    // Dark hour tens digit when the captured value is zero; the live input
    // is deliberately not consulted so blanking stays frame-coherent.
    if ((slot_q == SLOT_HOUR2) && (snap_hour2_q == 4'd0)) begin
      an_d  = AN_ALL_OFF;
      seg_d = SEG_ALL_OFF;
    end else begin
      an_d  = an_decode(slot_q);
      seg_d = seg_encode(digit_s);
    end
`endif

    // Colon dots sit on the minute-ones and hour-ones digits.
    dot_slot_s = (slot_q == SLOT_MIN1) || (slot_q == SLOT_HOUR1);
    if (phase_q && dot_slot_s) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // All state and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= {DIV_W{1'b0}};
      slot_q       <= SLOT_SEC1;
      blink_cnt_q  <= {BLK_W{1'b0}};
      phase_q      <= 1'b0;
      snap_sec1_q  <= 4'd0;
      snap_sec2_q  <= 4'd0;
      snap_min1_q  <= 4'd0;
      snap_min2_q  <= 4'd0;
      snap_hour1_q <= 4'd0;
      snap_hour2_q <= 4'd0;
      an_q         <= AN_ALL_OFF;
      seg_q        <= SEG_ALL_OFF;
      dp_q         <= 1'b1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      slot_q       <= slot_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      snap_sec1_q  <= snap_sec1_d;
      snap_sec2_q  <= snap_sec2_d;
      snap_min1_q  <= snap_min1_d;
      snap_min2_q  <= snap_min2_d;
      snap_hour1_q <= snap_hour1_d;
      snap_hour2_q <= snap_hour2_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan.
// The reference model counts clock edges since reset release and derives the
// slot, blink phase and frame snapshot with plain arithmetic.
module tb_clock_display_scan;

  localparam int SD    = 4;
  localparam int BD    = 8;
  localparam int FRAME = 6 * SD;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sec_1 = 4'd0, sec_2 = 4'd0, min_1 = 4'd0;
  logic [3:0] min_2 = 4'd0, hour_1 = 4'd0, hour_2 = 4'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1),
    .min_2(min_2), .hour_1(hour_1), .hour_2(hour_2),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_n = 0;                 // edges since reset release
  logic [3:0] m_snap [6] = '{default: 4'd0};
  logic [5:0] exp_an  = 6'b111111;
  logic [6:0] exp_seg = 7'b1111111;
  logic       exp_dp  = 1'b1;

  function automatic logic [5:0] ref_an(input int n, input logic [3:0] h2);
    int s;
    logic [5:0] r;
    s = (n / SD) % 6;
    r = 6'b111111;
    r[s] = 1'b0;
`ifdef CLOCK_DISP_LZ_BLANK_EN
    if (s == 5 && h2 == 4'd0) r = 6'b111111;
`endif
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int n, input logic [3:0] d, input logic [3:0] h2);
    int s;
    logic [6:0] r;
    s = (n / SD) % 6;
    if (d > 4'd9) r = 7'b0111111;
    else r = SEG_TAB[d];
`ifdef CLOCK_DISP_LZ_BLANK_EN
    if (s == 5 && h2 == 4'd0) r = 7'b1111111;
`endif
    return r;
  endfunction

  function automatic logic ref_dp(input int n);
    int s;
    s = (n / SD) % 6;
    return (((n / BD) % 2) == 1 && (s == 2 || s == 4)) ? 1'b0 : 1'b1;
  endfunction

  // Model update: outputs after this edge show the state of n edges so far.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_snap  <= '{default: 4'd0};
      exp_an  <= 6'b111111;
      exp_seg <= 7'b1111111;
      exp_dp  <= 1'b1;
    end else begin
      exp_an  <= ref_an(m_n, m_snap[5]);
      exp_seg <= ref_seg(m_n, m_snap[(m_n / SD) % 6], m_snap[5]);
      exp_dp  <= ref_dp(m_n);
      m_n     <= m_n + 1;
      if (((m_n + 1) % FRAME) == 0) begin
        m_snap[0] <= sec_1;  m_snap[1] <= sec_2;
        m_snap[2] <= min_1;  m_snap[3] <= min_2;
        m_snap[4] <= hour_1; m_snap[5] <= hour_2;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    sec_1 = 4'd9; sec_2 = 4'd5; min_1 = 4'd9; min_2 = 4'd5; hour_1 = 4'd3; hour_2 = 4'd2;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({an, seg, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL reset_hold: got an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({an, seg, dp} !== {6'b111110, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL reset_first_edge: got an=%b seg=%b dp=%b want 111110 1000000 1", an, seg, dp);
    end
    // Run past one snapshot, then reset mid-frame.
    for (int i = 0; i < FRAME + 6; i++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL reset_run: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({an, seg, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL reset_mid: got an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({an, seg, dp} !== {6'b111110, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL reset_restart: got an=%b seg=%b dp=%b want 111110 1000000 1", an, seg, dp);
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] seg_want [6];
    logic [5:0] an_want [6];
    seg_want = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    an_want  = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    @(negedge clk); rst_n = 1'b0;
    hour_2 = 4'd1; hour_1 = 4'd2; min_2 = 4'd3; min_1 = 4'd4; sec_2 = 4'd5; sec_1 = 4'd6;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL scan_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i >= FRAME) begin
        total++;
        if ({an, seg} !== {an_want[(i - FRAME) / SD], seg_want[(i - FRAME) / SD]}) begin
          bad++; $display("FAIL scan_order slot%0d: got an=%b seg=%b want an=%b seg=%b", (i - FRAME) / SD, an, seg, an_want[(i - FRAME) / SD], seg_want[(i - FRAME) / SD]);
        end
      end
    end
  endtask

  task automatic test_no_tear();
    int w;
    for (w = 0; w < 2 * FRAME && ((m_n / SD) % 6) != 3; w++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL tear_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    total++;
    if (((m_n / SD) % 6) != 3) begin
      bad++; $display("FAIL tear_sync: timeout waiting for slot 3, got %0d want 3", (m_n / SD) % 6);
    end
    sec_1 = 4'd7;
    min_1 = 4'd8;
    for (w = 0; w < 2 * FRAME && (m_n % FRAME) != 1; w++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL tear_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    total++;
    if ({an, seg} !== {6'b111110, 7'b1111000}) begin
      bad++; $display("FAIL tear_new_frame: got an=%b seg=%b want an=111110 seg=1111000", an, seg);
    end
  endtask

  task automatic test_invalid_bcd();
    int w;
    min_1 = 4'hA;
    @(negedge clk);
    for (w = 0; w < 2 * FRAME && (m_n % FRAME) != 0; w++) @(negedge clk);
    total++;
    if ((m_n % FRAME) != 0) begin
      bad++; $display("FAIL bcd_sync: timeout, got phase %0d want 0", m_n % FRAME);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL bcd_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i / SD == 2) begin
        total++;
        if ({an, seg} !== {6'b111011, 7'b0111111}) begin
          bad++; $display("FAIL bcd_dash: got an=%b seg=%b want an=111011 seg=0111111", an, seg);
        end
      end
    end
  endtask

  task automatic test_blank();
    int w;
    logic [5:0] an5;
    logic [6:0] seg5;
`ifdef CLOCK_DISP_LZ_BLANK_EN
    an5 = 6'b111111; seg5 = 7'b1111111;
`else
    an5 = 6'b011111; seg5 = 7'b1000000;
`endif
    hour_2 = 4'd0;
    @(negedge clk);
    for (w = 0; w < 2 * FRAME && (m_n % FRAME) != 0; w++) @(negedge clk);
    total++;
    if ((m_n % FRAME) != 0) begin
      bad++; $display("FAIL blank_sync: timeout, got phase %0d want 0", m_n % FRAME);
    end
    hour_2 = 4'd1;  // live input must not influence the captured digit
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL blank_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i / SD == 5) begin
        total++;
        if ({an, seg} !== {an5, seg5}) begin
          bad++; $display("FAIL blank_slot5: got an=%b seg=%b want an=%b seg=%b", an, seg, an5, seg5);
        end
      end
    end
  endtask

  task automatic test_blink();
    int lows;
    int s;
    lows = 0;
    sec_1 = 4'($urandom_range(0, 9)); min_1 = 4'($urandom_range(0, 9));
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      s = ((m_n - 1) / SD) % 6;
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL blink_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (dp === 1'b0) begin
        lows++;
        total++;
        if (!(s == 2 || s == 4)) begin
          bad++; $display("FAIL blink_slot: dp low in slot %0d, want only slot 2 or 4", s);
        end
      end
    end
    total++;
    if (lows != 16) begin
      bad++; $display("FAIL blink_count: got %0d dp-low cycles want 16", lows);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        bad++; $display("FAIL random_model: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ($urandom_range(0, 3) == 0) begin
        sec_1 = 4'($urandom_range(0, 15)); sec_2  = 4'($urandom_range(0, 15));
        min_1 = 4'($urandom_range(0, 15)); min_2  = 4'($urandom_range(0, 15));
        hour_1 = 4'($urandom_range(0, 15)); hour_2 = 4'($urandom_range(0, 2));
      end
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_no_tear();
    test_invalid_bcd();
    test_blank();
    test_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
